// File: rtl/mem_responder_pkg.sv
// Shared widths, limits and FSM encodings for the wait-state memory responder.
package mem_responder_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned WAIT_MAX   = 15;
   localparam int unsigned CNT_W      = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Request kind captured at accept.
   typedef struct packed {
      logic rd;
      logic wr;
   } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a one-cycle registered read; storage is never reset.
module mem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned AW     = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      // rdata only moves on a real read so it can serve as the held read result.
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: word RAM behind a programmable wait-state FSM with a 4-phase done handshake.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              done,
   output logic              err,
   output logic              busy
);

   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WAIT_STATES > WAIT_MAX) begin : gen_bad_wait
      $error("mem_responder: WAIT_STATES must be in 0..15");
   end
   if (DEPTH > (2 ** ADDR_W) || DEPTH == 0) begin : gen_bad_depth
      $error("mem_responder: DEPTH must be in 1..2**ADDR_W");
   end

   logic [1:0]        state_q;
   logic [CNT_W-1:0]  cnt_q;
   op_t               op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              done_q;
   logic              err_q;
   logic              out_zero_q;

   logic              in_range;
   logic              conflict;
   logic              access;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   assign in_range = 32'(addr_q) < DEPTH;
   assign conflict = op_q.rd & op_q.wr;
   assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
   assign mem_we   = access & op_q.wr & ~op_q.rd & in_range;
   assign mem_re   = access & op_q.rd & ~op_q.wr & in_range;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         out_zero_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (read | write) begin
                  op_q    <= '{rd: read, wr: write};
                  addr_q  <= addr;
                  wdata_q <= data_in;
                  cnt_q   <= CNT_W'(WAIT_STATES);
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= ST_RESP;
                  done_q  <= 1'b1;
                  err_q   <= conflict | ~in_range;
                  // Out-of-range reads return zero; conflicting requests leave data_out alone.
                  if (op_q.rd & ~op_q.wr) begin
                     out_zero_q <= ~in_range;
                  end
               end
            end
            ST_RESP: begin
               if (!read && !write) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (MEM_AW)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (addr_q[MEM_AW-1:0]),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   assign data_out = out_zero_q ? '0 : mem_rdata;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (slow full-depth, zero-wait half-depth).
module tb_mem_responder;

   localparam int unsigned WS0  = 2;
   localparam int unsigned WS1  = 0;
   localparam int unsigned DEP0 = 512;
   localparam int unsigned DEP1 = 256;

   logic        clk = 1'b0;
   logic        rst  [2];
   logic        rd   [2];
   logic        wr   [2];
   logic [8:0]  ad   [2];
   logic [31:0] din  [2];
   logic [31:0] dout [2];
   logic        done [2];
   logic        err  [2];
   logic        busy [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] ref_mem [2][512];
   logic [31:0] ref_out [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(
      .DATA_W (32), .ADDR_W (9), .DEPTH (DEP0), .WAIT_STATES (WS0)
   ) dut0 (
      .clk (clk), .reset (rst[0]), .read (rd[0]), .write (wr[0]), .addr (ad[0]),
      .data_in (din[0]), .data_out (dout[0]), .done (done[0]), .err (err[0]), .busy (busy[0])
   );

   mem_responder #(
      .DATA_W (32), .ADDR_W (9), .DEPTH (DEP1), .WAIT_STATES (WS1)
   ) dut1 (
      .clk (clk), .reset (rst[1]), .read (rd[1]), .write (wr[1]), .addr (ad[1]),
      .data_in (din[1]), .data_out (dout[1]), .done (done[1]), .err (err[1]), .busy (busy[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full handshake. hold>0 keeps requests high that many cycles past done;
   // hold<0 drops them right after accept.
   task automatic access(input int d, input bit r, input bit w, input logic [8:0] a,
                         input logic [31:0] wd, input int hold, output int acc_cyc);
      int unsigned ws;
      int unsigned dep;
      bit          e;
      bit          seen;
      bit          held_ok;
      int          k;
      logic [31:0] exp_out;
      ws  = (d == 0) ? WS0 : WS1;
      dep = (d == 0) ? DEP0 : DEP1;

      e = (r && w) || (32'(a) >= dep);
      if (r && !w) begin
         exp_out    = (32'(a) >= dep) ? 32'h0 : ref_mem[d][a];
         ref_out[d] = exp_out;
      end else begin
         exp_out = ref_out[d];
      end
      if (w && !r && 32'(a) < dep) ref_mem[d][a] = wd;

      @(negedge clk);
      rd[d] = r; wr[d] = w; ad[d] = a; din[d] = wd;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      check_eq("busy_after_accept", 32'(busy[d]), 32'h1);
      @(negedge clk);
      ad[d]  = 9'($urandom);
      din[d] = $urandom;
      if (hold < 0) begin
         rd[d] = 1'b0; wr[d] = 1'b0;
      end

      k = 0; seen = 1'b0;
      while (!seen && k < 40) begin
         @(posedge clk); #1;
         k++;
         if (done[d]) seen = 1'b1;
      end
      check_eq("latency", 32'(k), ws + 1);
      check_eq("err", 32'(err[d]), 32'(e));
      check_eq("data_out", dout[d], exp_out);

      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!done[d] || dout[d] !== exp_out) held_ok = 1'b0;
      end
      if (hold > 0) check_eq("done_held", 32'(held_ok), 32'h1);

      @(negedge clk);
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(posedge clk); #1;
      check_eq("done_dropped", 32'(done[d]), 32'h0);
      check_eq("busy_dropped", 32'(busy[d]), 32'h0);
      check_eq("err_dropped", 32'(err[d]), 32'h0);
   endtask

   initial begin
      int c;
      int prev;
      int d;
      int hold;
      logic [8:0] a;
      bit r;
      bit w;

      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; din[i] = '0;
         ref_out[i] = 32'h0;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("reset_done", 32'(done[i]), 32'h0);
         check_eq("reset_err", 32'(err[i]), 32'h0);
         check_eq("reset_busy", 32'(busy[i]), 32'h0);
         check_eq("reset_data", dout[i], 32'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Known contents for the address pools used below.
      for (int i = 0; i < 16; i++) begin
         access(0, 1'b0, 1'b1, 9'(i), $urandom, 0, c);
         access(1, 1'b0, 1'b1, 9'(i), $urandom, 0, c);
      end
      access(1, 1'b0, 1'b1, 9'h0FF, 32'h0FF0_0FF0, 0, c);

      // Reset mid-WAIT must not commit the write.
      access(0, 1'b0, 1'b1, 9'd5, 32'h1111_1111, 0, c);
      @(negedge clk);
      wr[0] = 1'b1; ad[0] = 9'd5; din[0] = 32'hDEAD_BEEF;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst[0] = 1'b1;
      #1;
      check_eq("midreset_done", 32'(done[0]), 32'h0);
      check_eq("midreset_err", 32'(err[0]), 32'h0);
      check_eq("midreset_busy", 32'(busy[0]), 32'h0);
      check_eq("midreset_data", dout[0], 32'h0);
      @(negedge clk);
      wr[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b0;
      ref_out[0] = 32'h0;
      access(0, 1'b1, 1'b0, 9'd5, 32'h0, 0, c);

      // Write then read back at WAIT_STATES=2, then a long hold on done.
      access(0, 1'b0, 1'b1, 9'h010, 32'h1234_5678, 0, c);
      access(0, 1'b1, 1'b0, 9'h010, 32'h0, 5, c);
      access(0, 1'b0, 1'b1, 9'h010, 32'hCAFE_F00D, 5, c);
      access(0, 1'b1, 1'b0, 9'h010, 32'h0, 0, c);

      // Conflicting request leaves memory and data_out alone.
      access(0, 1'b1, 1'b1, 9'd3, 32'h5555_AAAA, 0, c);
      access(0, 1'b1, 1'b0, 9'd3, 32'h0, 0, c);

      // Out of range on the 256-deep instance, no aliasing into 0xFF.
      access(1, 1'b1, 1'b0, 9'h0FF, 32'h0, 0, c);
      access(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 0, c);
      access(1, 1'b0, 1'b1, 9'h1FF, 32'h7777_7777, 0, c);
      access(1, 1'b1, 1'b0, 9'h0FF, 32'h0, 0, c);

      // Zero wait states: back-to-back reads every WAIT_STATES+3 cycles.
      access(1, 1'b0, 1'b1, 9'd0, 32'hA, 0, c);
      access(1, 1'b0, 1'b1, 9'd1, 32'hB, 0, c);
      access(1, 1'b0, 1'b1, 9'd2, 32'hC, 0, c);
      access(1, 1'b1, 1'b0, 9'd0, 32'h0, 0, prev);
      for (int i = 1; i < 3; i++) begin
         access(1, 1'b1, 1'b0, 9'(i), 32'h0, 0, c);
         check_eq("b2b_period", 32'(c - prev), WS1 + 3);
         prev = c;
      end

      // Randomized mix, including early drops and long holds.
      for (int n = 0; n < 150; n++) begin
         d    = int'($urandom_range(1, 0));
         hold = int'($urandom_range(3, 0)) - 1;
         case ($urandom_range(9, 0))
            0:       begin r = 1'b1; w = 1'b1; end
            1, 2, 3: begin r = 1'b0; w = 1'b1; end
            default: begin r = 1'b1; w = 1'b0; end
         endcase
         if (d == 1 && $urandom_range(4, 0) == 0) a = 9'($urandom_range(511, 256));
         else a = 9'($urandom_range(15, 0));
         access(d, r, w, a, $urandom, hold, c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
